grid_cursor_renderer: RTL

Parametrised COLS×ROWS grid renderer with a registered cursor and a per-cell mark bitmap. It sits between `driver_vga_1024x768` and the top-level VGA color mux, and takes over from the fixed 6×4 template plus the cursor compare. Cell position is tracked with incremental per-pixel counters, with no division. The block produces a registered 12-bit pixel color two cycles after the pixel coordinates are presented.

---
 rtl/grid_cursor_renderer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/grid_cursor_renderer.sv
// Grid renderer with a registered cursor and a per-cell mark bitmap.
// The pixel colour is registered two clocks after the coordinates arrive.
module grid_cursor_renderer #(
   parameter int          COLS         = 6,
   parameter int          ROWS         = 4,
   parameter int          CELL_W       = 100,
   parameter int          CELL_H       = 100,
   parameter int          X0           = 212,
   parameter int          Y0           = 184,
   parameter int          WRAP         = 1,
   parameter logic [11:0] LINE_COLOR   = 12'h000,
   parameter logic [11:0] BG_COLOR     = 12'hFFF,
   parameter logic [11:0] CURSOR_COLOR = 12'hF00,
   parameter logic [11:0] MARK_COLOR   = 12'h0F0,
   localparam int         CXW          = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int         CYW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                 CLK82MHZ,
   input  logic                 CPU_RESETN,
   input  logic [10:0]          hc_visible,
   input  logic [10:0]          vc_visible,
   input  logic                 move_up,
   input  logic                 move_down,
   input  logic                 move_left,
   input  logic                 move_right,
   input  logic                 toggle,
   input  logic                 clear,
   output logic [CXW-1:0]       cursor_x,
   output logic [CYW-1:0]       cursor_y,
   output logic [COLS*ROWS-1:0] marks,
   output logic [11:0]          pix_color,
   output logic                 pix_in_grid
);

   localparam int NCELL = COLS * ROWS;
   localparam int MW    = (NCELL > 1) ? $clog2(NCELL) : 1;
   localparam int XW    = $clog2(CELL_W);
   localparam int YW    = $clog2(CELL_H);
   localparam int X_END = X0 + COLS * CELL_W;
   localparam int Y_END = Y0 + ROWS * CELL_H;

   localparam logic [CXW-1:0] COL_LAST  = CXW'(COLS - 1);
   localparam logic [CYW-1:0] ROW_LAST  = CYW'(ROWS - 1);
   localparam logic [CXW-1:0] COL_ONE   = CXW'(1);
   localparam logic [CYW-1:0] ROW_ONE   = CYW'(1);
   localparam logic [XW-1:0]  XOFF_LAST = XW'(CELL_W - 1);
   localparam logic [YW-1:0]  YOFF_LAST = YW'(CELL_H - 1);
   localparam logic [XW-1:0]  XOFF_ONE  = XW'(1);
   localparam logic [YW-1:0]  YOFF_ONE  = YW'(1);

   logic [CXW-1:0]   cursor_x_next;
   logic [CYW-1:0]   cursor_y_next;
   logic [NCELL-1:0] marks_next;
   logic [MW-1:0]    cursor_idx;

   logic             in_x, in_y, x_first, y_first;
   logic [CXW-1:0]   col, col_next;
   logic [CYW-1:0]   row, row_next;
   logic [XW-1:0]    xoff, xoff_next;
   logic [YW-1:0]    yoff, yoff_next;
   logic             line_next, blank_next;
   logic             s1_in_grid, s1_line, s1_blank;
   logic [MW-1:0]    cell_idx;
   logic [11:0]      color_next;

   // Edge handling compares against the last index explicitly so that
   // non-power-of-two grids never rely on counter overflow.
   always_comb begin
      cursor_x_next = cursor_x;
      if (move_right && !move_left) begin
         if (cursor_x == COL_LAST) cursor_x_next = (WRAP != 0) ? '0 : cursor_x;
         else                      cursor_x_next = cursor_x + COL_ONE;
      end else if (move_left && !move_right) begin
         if (cursor_x == '0) cursor_x_next = (WRAP != 0) ? COL_LAST : cursor_x;
         else                cursor_x_next = cursor_x - COL_ONE;
      end

      cursor_y_next = cursor_y;
      if (move_down && !move_up) begin
         if (cursor_y == ROW_LAST) cursor_y_next = (WRAP != 0) ? '0 : cursor_y;
         else                      cursor_y_next = cursor_y + ROW_ONE;
      end else if (move_up && !move_down) begin
         if (cursor_y == '0) cursor_y_next = (WRAP != 0) ? ROW_LAST : cursor_y;
         else                cursor_y_next = cursor_y - ROW_ONE;
      end
   end

   assign cursor_idx = MW'(int'(cursor_y) * COLS + int'(cursor_x));

   always_comb begin
      marks_next = marks;
      if (clear)       marks_next = '0;
      else if (toggle) marks_next[cursor_idx] = ~marks[cursor_idx];
   end

   assign in_x    = (int'(hc_visible) > X0) && (int'(hc_visible) <= X_END);
   assign in_y    = (int'(vc_visible) > Y0) && (int'(vc_visible) <= Y_END);
   assign x_first = (int'(hc_visible) == X0 + 1);
   assign y_first = (int'(vc_visible) == Y0 + 1);

   // Row counters only advance on the first grid pixel of each line.
   always_comb begin
      col_next  = col;
      xoff_next = xoff;
      row_next  = row;
      yoff_next = yoff;
      if (x_first) begin
         col_next  = '0;
         xoff_next = '0;
         if (y_first) begin
            row_next  = '0;
            yoff_next = '0;
         end else if (in_y) begin
            if (yoff == YOFF_LAST) begin
               yoff_next = '0;
               row_next  = row + ROW_ONE;
            end else begin
               yoff_next = yoff + YOFF_ONE;
            end
         end
      end else if (in_x) begin
         if (xoff == XOFF_LAST) begin
            xoff_next = '0;
            col_next  = col + COL_ONE;
         end else begin
            xoff_next = xoff + XOFF_ONE;
         end
      end
   end

   assign line_next  = (xoff_next == '0) || (yoff_next == '0) ||
                       (int'(hc_visible) == X_END) || (int'(vc_visible) == Y_END);
   assign blank_next = (hc_visible == 11'd0) || (vc_visible == 11'd0);
   assign cell_idx   = MW'(int'(row) * COLS + int'(col));

   always_comb begin
      color_next = BG_COLOR;
      if (s1_blank)                                color_next = 12'h000;
      else if (!s1_in_grid)                        color_next = BG_COLOR;
      else if (s1_line)                            color_next = LINE_COLOR;
      else if (col == cursor_x && row == cursor_y) color_next = CURSOR_COLOR;
      else if (marks[cell_idx])                    color_next = MARK_COLOR;
   end

   always_ff @(posedge CLK82MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         cursor_x    <= '0;
         cursor_y    <= '0;
         marks       <= '0;
         col         <= '0;
         row         <= '0;
         xoff        <= '0;
         yoff        <= '0;
         s1_in_grid  <= 1'b0;
         s1_line     <= 1'b0;
         s1_blank    <= 1'b0;
         pix_color   <= 12'h000;
         pix_in_grid <= 1'b0;
      end else begin
         cursor_x    <= cursor_x_next;
         cursor_y    <= cursor_y_next;
         marks       <= marks_next;
         col         <= col_next;
         row         <= row_next;
         xoff        <= xoff_next;
         yoff        <= yoff_next;
         s1_in_grid  <= in_x && in_y;
         s1_line     <= line_next;
         s1_blank    <= blank_next;
         pix_color   <= color_next;
         pix_in_grid <= s1_in_grid;
      end
   end

endmodule
